// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// error cause codes and the frame magic byte.
package imem_loader_pkg;

  // FSM state encoding, kept as plain constants for legacy compatibility
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAGIC = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // Error cause reported on ERR_CODE while ERR is set
  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  // First byte of every load frame
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // States in which the loader consumes bytes from the host stream
  function automatic logic is_rx_state(input logic [2:0] s);
    return (s == ST_MAGIC) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler with running XOR checksum.
// word/word_valid present a completed word for one cycle after its 4th byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        lane_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [23:0] asm_q;
  logic [1:0]  byte_idx;

  // The next accepted byte completes the current word
  assign lane_last = (byte_idx == 2'd3);

  // Byte lane assembly, checksum accumulation and completed-word strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        asm_q    <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end else if (byte_en) begin
        csum <= csum ^ byte_in;
        case (byte_idx)
          2'd0: asm_q[7:0]   <= byte_in;
          2'd1: asm_q[15:8]  <= byte_in;
          2'd2: asm_q[23:16] <= byte_in;
          default: begin
            word       <= {byte_in, asm_q};
            word_valid <= 1'b1;
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction memory loader: parses a framed byte stream
// (magic, word count, little-endian words, XOR checksum), writes one
// instruction word per WE pulse and holds the core stalled while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [31:0]       WDATA,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        ERR_CODE
);

  // Word index carries one extra bit so a count of DEPTH never wraps
  localparam int WI_W = ADDR_W + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic              rx_ready;
  logic              busy;
  logic              hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] waddr;
  logic [WI_W-1:0]   n_words;
  logic [WI_W-1:0]   word_idx;
  logic [TO_W-1:0]   idle_cnt;

  logic              accept;
  logic              len_ok;
  logic              timeout_hit;
  logic              start_ok;
  logic              fail;
  logic [1:0]        fail_code;
  logic              finish;
  logic              pk_clear;
  logic              pk_en;
  logic              word_done;

  logic              pk_lane_last;
  logic              pk_word_valid;
  logic [31:0]       pk_word;
  logic [7:0]        pk_csum;

  assign accept      = RX_VALID && rx_ready;
  assign len_ok      = (RX_DATA != 8'd0) && (int'(RX_DATA) <= DEPTH);
  assign timeout_hit = is_rx_state(state) && !accept
                       && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
  // busy is still high in the DONE cycle, so a START there is ignored too
  assign start_ok    = (state == ST_IDLE) && START && !busy;
  assign word_done   = (state == ST_DATA) && accept && pk_lane_last;

  imem_word_packer u_packer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (pk_clear),
    .byte_en    (pk_en),
    .byte_in    (RX_DATA),
    .lane_last  (pk_lane_last),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .csum       (pk_csum)
  );

  // Next-state and error-cause decode for the frame parser
  always_comb begin
    state_d   = state;
    fail      = 1'b0;
    fail_code = ERR_TIMEOUT;
    finish    = 1'b0;
    pk_clear  = 1'b0;
    pk_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_d = ST_MAGIC;
      end
      ST_MAGIC: begin
        if (accept) begin
          if (RX_DATA == LOADER_MAGIC) begin
            state_d = ST_LEN;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_MAGIC;
          end
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_ok) begin
            state_d  = ST_DATA;
            pk_clear = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_en = 1'b1;
          if (pk_lane_last && (word_idx == n_words - WI_W'(1))) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (RX_DATA == pk_csum) begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CSUM;
          end
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout_hit) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
    if (fail) state_d = ST_ERROR;
  end

  // State, handshake, status flags, word addressing and idle timer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      hold     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      waddr    <= '0;
      n_words  <= '0;
      word_idx <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_d;
      rx_ready <= is_rx_state(state_d);
      done     <= finish;

      // Success is released one edge after the DONE pulse, back in IDLE
      if ((state == ST_IDLE) && done) begin
        busy <= 1'b0;
        hold <= 1'b0;
      end
      if (start_ok) begin
        busy <= 1'b1;
        hold <= 1'b1;
        err  <= 1'b0;
      end
      // hold is deliberately left set: a failed load leaves a corrupt image
      if (fail) begin
        err      <= 1'b1;
        err_code <= fail_code;
        busy     <= 1'b0;
      end

      if ((state == ST_LEN) && accept && len_ok) begin
        n_words  <= WI_W'(RX_DATA);
        word_idx <= '0;
      end
      if (word_done) begin
        waddr    <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + WI_W'(1);
      end

      if (accept || !is_rx_state(state)) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end

  assign RX_READY = rx_ready;
  assign WE       = pk_word_valid;
  assign WADDR    = waddr;
  assign WDATA    = pk_word;
  assign CPU_HOLD = hold;
  assign BUSY     = busy;
  assign DONE     = done;
  assign ERR      = err;
  assign ERR_CODE = err_code;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: valid loads, framing errors, length
// bounds, checksum mismatch, timeout, START-while-busy and async reset.
module tb_imem_loader;

  localparam int ADDR_W = 7;

  logic              CLK;
  logic              RESET_N;
  logic              START;
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [31:0]       WDATA;
  logic              CPU_HOLD;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [1:0]        ERR_CODE;

  int vecs;
  int errs;

  int          we_n;
  int          done_n;
  logic [6:0]  we_addr [1024];
  logic [31:0] we_data [1024];

  imem_loader #(
    .DEPTH       (128),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .WE       (WE),
    .WADDR    (WADDR),
    .WDATA    (WDATA),
    .CPU_HOLD (CPU_HOLD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every memory write and DONE pulse, sampled mid-cycle
  initial begin
    we_n   = 0;
    done_n = 0;
  end
  always @(negedge CLK) begin
    if (WE === 1'b1 && we_n < 1024) begin
      we_addr[we_n] = WADDR;
      we_data[we_n] = WDATA;
      we_n++;
    end
    if (DONE === 1'b1) done_n++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, vecs=%0d", vecs);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] big_byte(input int i);
    int v;
    v = (i * 37 + 11) & 255;
    return 8'(v);
  endfunction

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    guard    = 0;
    while (RX_READY !== 1'b1 && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (RX_READY !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL rx_ready_wait: RX_READY=%b required 1 for byte %02h", RX_READY, b);
    end
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    vecs = 0; errs = 0;
    #12;
    vecs++;
    if ({RX_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE} !== 47'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h required 0",
               {RX_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE});
    end
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    vecs++;
    if ({BUSY, RX_READY, CPU_HOLD} !== 3'b000) begin
      errs++; $display("FAIL idle_after_reset: busy/ready/hold=%b required 000", {BUSY, RX_READY, CPU_HOLD});
    end
  endtask

  task automatic test_valid_load();
    int base;
    int dbase;
    base = we_n; dbase = done_n;
    pulse_start();
    vecs++;
    if ({BUSY, CPU_HOLD, RX_READY, ERR} !== 4'b1110) begin
      errs++; $display("FAIL start_arms: busy/hold/ready/err=%b required 1110", {BUSY, CPU_HOLD, RX_READY, ERR});
    end
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h04); send_byte(8'h12); send_byte(8'h9F); send_byte(8'hE5);
    vecs++;
    if ({WE, WADDR, WDATA} !== {1'b1, 7'd0, 32'hE59F1204}) begin
      errs++; $display("FAIL word0_strobe: we=%b addr=%0d data=%h required 1/0/e59f1204", WE, WADDR, WDATA);
    end
    send_byte(8'h04); send_byte(8'h92); send_byte(8'h9F); send_byte(8'hE5);
    // XOR of the eight data bytes is 0x80
    send_byte(8'h80);
    vecs++;
    if ({DONE, CPU_HOLD, BUSY} !== 3'b111) begin
      errs++; $display("FAIL done_pulse: done/hold/busy=%b required 111", {DONE, CPU_HOLD, BUSY});
    end
    @(posedge CLK); #1;
    vecs++;
    if ({DONE, CPU_HOLD, BUSY, RX_READY, ERR} !== 5'b00000) begin
      errs++; $display("FAIL release_after_done: done/hold/busy/ready/err=%b required 00000",
                       {DONE, CPU_HOLD, BUSY, RX_READY, ERR});
    end
    vecs++;
    if (we_n - base != 2 || we_addr[base] !== 7'd0 || we_data[base] !== 32'hE59F1204
        || we_addr[base+1] !== 7'd1 || we_data[base+1] !== 32'hE59F9204) begin
      errs++; $display("FAIL valid_writes: count=%0d a0=%0d d0=%h a1=%0d d1=%h required 2/0/e59f1204/1/e59f9204",
                       we_n - base, we_addr[base], we_data[base], we_addr[base+1], we_data[base+1]);
    end
    vecs++;
    if (done_n - dbase != 1) begin
      errs++; $display("FAIL done_count: got %0d required 1", done_n - dbase);
    end
  endtask

  task automatic test_bad_magic();
    int base;
    base = we_n;
    pulse_start();
    send_byte(8'h5A);
    vecs++;
    if ({ERR, ERR_CODE, BUSY, RX_READY, CPU_HOLD} !== 6'b1_01_001) begin
      errs++; $display("FAIL bad_magic: err/code/busy/ready/hold=%b required 101001",
                       {ERR, ERR_CODE, BUSY, RX_READY, CPU_HOLD});
    end
    idle_cycles(3);
    vecs++;
    if (we_n != base || CPU_HOLD !== 1'b1 || ERR !== 1'b1) begin
      errs++; $display("FAIL bad_magic_after: writes=%0d hold=%b err=%b required 0/1/1", we_n - base, CPU_HOLD, ERR);
    end
  endtask

  task automatic test_len_bounds();
    int base;
    int dbase;
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] w;
    int bad;
    // N = 0
    pulse_start();
    vecs++;
    if (ERR !== 1'b0) begin
      errs++; $display("FAIL start_clears_err: err=%b required 0", ERR);
    end
    send_byte(8'hA5); send_byte(8'h00);
    vecs++;
    if ({ERR, ERR_CODE, BUSY} !== 4'b1_10_0) begin
      errs++; $display("FAIL len_zero: err/code/busy=%b required 1100", {ERR, ERR_CODE, BUSY});
    end
    idle_cycles(3);
    // N = 129
    pulse_start();
    send_byte(8'hA5); send_byte(8'd129);
    vecs++;
    if ({ERR, ERR_CODE, BUSY, CPU_HOLD} !== 5'b1_10_01) begin
      errs++; $display("FAIL len_129: err/code/busy/hold=%b required 11001", {ERR, ERR_CODE, BUSY, CPU_HOLD});
    end
    idle_cycles(3);
    // N = 128, full memory
    base = we_n; dbase = done_n; cs = 8'h00;
    pulse_start();
    send_byte(8'hA5); send_byte(8'd128);
    for (int i = 0; i < 512; i++) begin
      b = big_byte(i);
      cs = cs ^ b;
      send_byte(b);
    end
    send_byte(cs);
    vecs++;
    if (DONE !== 1'b1 || ERR !== 1'b0) begin
      errs++; $display("FAIL full_done: done=%b err=%b required 1/0", DONE, ERR);
    end
    @(posedge CLK); #1;
    vecs++;
    if (we_n - base != 128) begin
      errs++; $display("FAIL full_count: got %0d writes required 128", we_n - base);
    end
    vecs++;
    if (we_addr[base+127] !== 7'd127) begin
      errs++; $display("FAIL full_last_addr: got %0d required 127", we_addr[base+127]);
    end
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      w = {big_byte(4*k+3), big_byte(4*k+2), big_byte(4*k+1), big_byte(4*k)};
      if (we_addr[base+k] !== 7'(k) || we_data[base+k] !== w) begin
        if (bad == 0)
          $display("FAIL full_word: index %0d addr=%0d data=%h required %0d/%h",
                   k, we_addr[base+k], we_data[base+k], k, w);
        bad++;
      end
    end
    vecs++;
    if (bad != 0) errs++;
    vecs++;
    if (CPU_HOLD !== 1'b0 || done_n - dbase != 1) begin
      errs++; $display("FAIL full_release: hold=%b dones=%0d required 0/1", CPU_HOLD, done_n - dbase);
    end
  endtask

  task automatic test_csum_mismatch();
    int base;
    base = we_n;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h04); send_byte(8'h12); send_byte(8'h9F); send_byte(8'hE5);
    send_byte(8'h04); send_byte(8'h92); send_byte(8'h9F); send_byte(8'hE5);
    send_byte(8'hFF);
    vecs++;
    if ({ERR, ERR_CODE, BUSY, CPU_HOLD, DONE} !== 6'b1_11_010) begin
      errs++; $display("FAIL csum_err: err/code/busy/hold/done=%b required 111010",
                       {ERR, ERR_CODE, BUSY, CPU_HOLD, DONE});
    end
    vecs++;
    if (we_n - base != 2 || we_data[base] !== 32'hE59F1204 || we_data[base+1] !== 32'hE59F9204
        || we_addr[base+1] !== 7'd1) begin
      errs++; $display("FAIL csum_writes: count=%0d d0=%h d1=%h a1=%0d required 2/e59f1204/e59f9204/1",
                       we_n - base, we_data[base], we_data[base+1], we_addr[base+1]);
    end
    idle_cycles(3);
  endtask

  task automatic test_timeout();
    int base;
    base = we_n;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h04); send_byte(8'h12); send_byte(8'h9F);
    idle_cycles(15);
    vecs++;
    if ({ERR, BUSY} !== 2'b01) begin
      errs++; $display("FAIL timeout_early: err/busy=%b required 01 after 15 idle cycles", {ERR, BUSY});
    end
    idle_cycles(1);
    vecs++;
    if ({ERR, ERR_CODE, BUSY, CPU_HOLD, RX_READY} !== 6'b1_00_010) begin
      errs++; $display("FAIL timeout_err: err/code/busy/hold/ready=%b required 100010",
                       {ERR, ERR_CODE, BUSY, CPU_HOLD, RX_READY});
    end
    vecs++;
    if (we_n != base) begin
      errs++; $display("FAIL timeout_no_we: got %0d writes required 0", we_n - base);
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    int base;
    base = we_n;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h04); send_byte(8'h12);
    pulse_start();
    vecs++;
    if ({BUSY, ERR, RX_READY} !== 3'b101) begin
      errs++; $display("FAIL start_ignored: busy/err/ready=%b required 101", {BUSY, ERR, RX_READY});
    end
    send_byte(8'h9F); send_byte(8'hE5);
    send_byte(8'h04); send_byte(8'h92); send_byte(8'h9F); send_byte(8'hE5);
    send_byte(8'h80);
    vecs++;
    if (DONE !== 1'b1 || we_n - base != 2 || we_data[base] !== 32'hE59F1204
        || we_data[base+1] !== 32'hE59F9204) begin
      errs++; $display("FAIL start_busy_load: done=%b count=%0d d0=%h d1=%h required 1/2/e59f1204/e59f9204",
                       DONE, we_n - base, we_data[base], we_data[base+1]);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_load();
    int base;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h04); send_byte(8'h12);
    #2 RESET_N = 1'b0;
    #1;
    vecs++;
    if ({RX_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE} !== 47'd0) begin
      errs++; $display("FAIL async_reset: got %h required 0",
                       {RX_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE});
    end
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    base = we_n;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    // 78 ^ 56 ^ 34 ^ 12 = 08
    send_byte(8'h08);
    vecs++;
    if (DONE !== 1'b1 || we_n - base != 1 || we_addr[base] !== 7'd0 || we_data[base] !== 32'h12345678) begin
      errs++; $display("FAIL reload_after_reset: done=%b count=%0d a=%0d d=%h required 1/1/0/12345678",
                       DONE, we_n - base, we_addr[base], we_data[base]);
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_valid_load();
    test_bad_magic();
    test_len_bounds();
    test_csum_mismatch();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
